int_arb: RTL

- Parametrised interrupt arbiter for the 65C02 core. It generalises the single NMI edge detector and IRQ/I gating into NUM_SRC sources.
- Each source is configurable as edge- or level-sensitive, and as maskable or non-maskable by the I flag.
- It arbitrates at each instruction boundary (sync & rdy) and tracks the post-reset vector fetch.
- It sits beside the control state machine, which uses int_req to divert SYNC into the BRK sequence and uses vector to address the {FF, vector} fetch.

---
 rtl/int_arb.sv | 91 +++++++++
 1 files changed

// File: rtl/int_arb.sv
// Interrupt arbiter: per-source edge/level capture, I-flag gating and fixed-priority
// selection at instruction boundaries, including the post-reset vector fetch.
module int_arb #(
    parameter int unsigned               NUM_SRC   = 2,
    parameter logic [NUM_SRC-1:0]        EDGE_MASK = 2'b10,
    parameter logic [NUM_SRC-1:0]        NMI_MASK  = 2'b10,
    parameter logic [NUM_SRC*8-1:0]      VEC_TABLE = {8'hFA, 8'hFE},
    parameter logic [7:0]                RST_VEC   = 8'hFC,
    localparam int unsigned              SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               I,
    input  logic               sync,
    input  logic               rdy,
    output logic               int_req,
    output logic               take,
    output logic [7:0]         vector,
    output logic [SRC_W-1:0]   src_id,
    output logic               rst_pend,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0] in_d;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] edge_d;
    logic [NUM_SRC-1:0] set_edge;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] win_onehot;
    logic [SRC_W-1:0]   win_idx;
    logic [7:0]         win_vec;
    logic               accept;
    logic               src_accept;

    // Edge bits come from the latch, level bits follow the pin directly.
    assign set_edge = irq_in & ~in_d & EDGE_MASK;
    assign pending  = (edge_q & EDGE_MASK) | (irq_in & ~EDGE_MASK);
    assign elig     = pending & (NMI_MASK | {NUM_SRC{~I}});
    assign int_req  = rst_pend | (|elig);
    assign accept   = sync & rdy & int_req;
    assign src_accept = accept & ~rst_pend;

    // Lowest eligible index wins.
    always_comb begin
        win_idx    = '0;
        win_vec    = RST_VEC;
        win_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx    = SRC_W'(i);
                win_vec    = VEC_TABLE[i*8 +: 8];
                win_onehot = NUM_SRC'(1) << i;
            end
        end
    end

    // A new edge in the accepting cycle re-arms the bit so it is not lost.
    always_comb begin
        edge_d = edge_q;
        if (src_accept) begin
            edge_d = edge_d & ~win_onehot;
        end
        edge_d = (edge_d | set_edge) & EDGE_MASK;
    end

    always_ff @(posedge clk) begin
        in_d <= irq_in;
        if (reset) begin
            edge_q   <= '0;
            take     <= 1'b0;
            vector   <= RST_VEC;
            src_id   <= '0;
            rst_pend <= 1'b1;
        end else begin
            edge_q <= edge_d;
            take   <= accept;
            if (accept) begin
                if (rst_pend) begin
                    vector   <= RST_VEC;
                    src_id   <= '0;
                    rst_pend <= 1'b0;
                end else begin
                    vector <= win_vec;
                    src_id <= win_idx;
                end
            end
        end
    end

endmodule
